iomem_ip_arbiter: RTL
=====================

# iomem_ip_arbiter

Two-master arbiter and transaction sequencer that shares the single hard-IP window (iomem 0x05xx_xxxx, serving the I2C, SPI and PWM wrapper) between the PicoRV32 iomem port and a second autonomous requester, such as a future LED or sensor-polling sequencer. It grants the target round-robin and carries one transaction at a time. A watchdog completes any access the target never acknowledges, so no master stalls forever.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: number of target-wait cycles before forced completion; legal range 1..65535.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned to the master on timeout.

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- resetn, in, 1: reset, synchronous, active-low.
- m0_valid, in, 1: master 0 (CPU) request.
- m0_ready, out, 1: master 0 completion pulse.
- m0_wstrb, in, 4: master 0 byte strobes; 0 means read.
- m0_addr, in, 32: master 0 address.
- m0_wdata, in, 32: master 0 write data.
- m0_rdata, out, 32: master 0 read data.
- m1_valid, m1_ready, m1_wstrb, m1_addr, m1_wdata, m1_rdata: the same set for master 1 (secondary requester).
- s_valid, out, 1: target request.
- s_ready, in, 1: target acknowledge.
- s_wstrb, out, 4: target byte strobes.
- s_addr, out, 24: target address, taken as m_addr[23:0].
- s_wdata, out, 32: target write data.
- s_rdata, in, 32: target read data.
- grant, out, 2: one-hot owner during BUSY and RESP; 0 in IDLE.
- timeout_flag, out, 1: sticky flag, set on any timeout.
- timeout_clr, in, 1: clears timeout_flag.

## Operation
Bus protocol (picorv32 style):
- A master holds valid, addr, wdata and wstrb stable until it samples ready=1.
- The cycle after that, the master deasserts valid or presents a new transaction.
- m*_ready is a single-cycle pulse.

FSM states are IDLE, BUSY and RESP.
- **IDLE:**
  - If neither valid is set, stay in IDLE.
  - If exactly one valid is set, grant that master.
  - If both are set, grant the master that is not last_grant.
  - On grant: latch that master's addr[23:0], wdata and wstrb into s_*; set s_valid=1; clear the timeout counter; set grant; update last_grant; go to BUSY.
- **BUSY:**
  - s_valid stays high and s_* stay stable; the counter increments each cycle.
  - If s_ready=1: latch s_rdata into the granted master's rdata, set s_valid=0, set that master's ready=1, go to RESP.
  - Otherwise, if the counter equals TIMEOUT_CYCLES-1: load ERR_DATA into the granted master's rdata, set s_valid=0, set ready=1, set timeout_flag, go to RESP.
  - If s_ready and the timeout condition occur in the same cycle, s_ready wins: real data is returned and the flag is not set.
- **RESP:**
  - The granted master's ready is high for exactly this cycle.
  - The next state is IDLE, with ready=0 and grant=0.
  - A new request can be granted no earlier than the cycle after RESP.

Other rules:
- rdata is also latched on writes. Each master's rdata holds its value until that master's next completion; the other master's rdata is never disturbed.
- s_ready is ignored outside BUSY.
- Master valid is not sampled in BUSY or RESP. A requester simply waits.
- timeout_flag: timeout_clr clears it, but a timeout set in the same cycle takes priority.
- The timeout counter is 16 bits and never wraps while in BUSY.

## Timing
Reset values (applied while resetn=0 at a clock edge, including mid-transaction):
- state=IDLE, s_valid=0, m0_ready=0, m1_ready=0.
- grant=0, timeout_flag=0, counter=0.
- m0_rdata=0, m1_rdata=0, s_addr/s_wdata/s_wstrb=0.
- last_grant=1, so master 0 wins the first contention.
- An in-flight target access is abandoned; no ready is issued for it.

Cycle-level behaviour:
- Latency: m_valid sampled at edge E gives s_valid=1 after E. If s_ready=1 in the first BUSY cycle, m_ready=1 in the cycle after E+1, so the best case is 2 cycles from the valid-sampling edge to the ready cycle.
- Throughput: at most one transaction every 3 cycles plus target wait.
- Timeout: with no s_ready, m_ready asserts in the cycle after the TIMEOUT_CYCLES-th BUSY cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Single read:** m0 reads addr 0x0500_0010; target answers s_ready on its 3rd BUSY cycle with 0x1234_5678. Required: s_addr=0x00_0010, s_wstrb=0, m0_ready pulses once, m0_rdata=0x1234_5678, grant=01 then 00.
- **Contention:** m0 and m1 are both valid from reset release. Required grant sequence 01, 10, 01, 10 across four back-to-back transactions; each master's rdata matches its own target reply.
- **Timeout:** TIMEOUT_CYCLES=8 and the target never acknowledges an m1 write of 0xA5A5_A5A5. Required: s_valid high for exactly 8 cycles, m1_ready pulses, m1_rdata=0xDEAD_BEEF, timeout_flag=1 until timeout_clr is pulsed, then 0.
- **Race:** s_ready arrives in the same cycle the counter reaches TIMEOUT_CYCLES-1. Required: target data is returned and timeout_flag stays 0.
- **Reset mid-BUSY:** resetn=0 for one cycle during an m0 access. Required: s_valid=0 and no m0_ready pulse; all outputs at reset values; the next m1 request is granted normally.
- **Stray s_ready:** s_ready is pulsed while in IDLE. Required: no state change and no m_ready.

Source files
------------

// File: rtl/iomem_ip_arbiter.sv
// iomem_ip_arbiter: round-robin arbiter and one-at-a-time sequencer that
// shares the hard-IP iomem window between two picorv32-style masters, with a
// watchdog that force-completes accesses the target never acknowledges.
module iomem_ip_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [23:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_flag,
    input  logic        timeout_clr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic        last_grant;    // 0: master 0 was served last, 1: master 1
    logic [15:0] cnt;

    logic        do_grant;
    logic        pick_m1;
    logic        do_done;
    logic        do_timeout;
    logic [31:0] done_data;

    // Upper address bits select the iomem window and are decoded upstream.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{m0_addr[31:24], m1_addr[31:24]};

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: arbitration in IDLE, completion/timeout in BUSY.
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        pick_m1    = 1'b0;
        do_done    = 1'b0;
        do_timeout = 1'b0;
        done_data  = s_rdata;
        case (state)
            ST_IDLE: begin
                if (m0_valid || m1_valid) begin
                    do_grant   = 1'b1;
                    pick_m1    = (m0_valid && m1_valid) ? ~last_grant : m1_valid;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // s_ready is checked first so a late acknowledge beats the watchdog.
                if (s_ready) begin
                    do_done    = 1'b1;
                    state_next = ST_RESP;
                end else if (cnt == CNT_LAST) begin
                    do_done    = 1'b1;
                    do_timeout = 1'b1;
                    done_data  = ERR_DATA;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered datapath: target request, per-master responses, watchdog, flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s_valid      <= 1'b0;
            s_addr       <= '0;
            s_wdata      <= '0;
            s_wstrb      <= '0;
            grant        <= '0;
            last_grant   <= 1'b1;
            cnt          <= '0;
            m0_ready     <= 1'b0;
            m1_ready     <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;

            if (do_grant) begin
                s_valid    <= 1'b1;
                cnt        <= '0;
                grant      <= pick_m1 ? 2'b10 : 2'b01;
                last_grant <= pick_m1;
                s_addr     <= pick_m1 ? m1_addr[23:0] : m0_addr[23:0];
                s_wdata    <= pick_m1 ? m1_wdata : m0_wdata;
                s_wstrb    <= pick_m1 ? m1_wstrb : m0_wstrb;
            end else if (state == ST_BUSY && !do_done) begin
                cnt <= cnt + 16'd1;
            end

            if (do_done) begin
                s_valid <= 1'b0;
                if (grant[1]) begin
                    m1_rdata <= done_data;
                    m1_ready <= 1'b1;
                end else begin
                    m0_rdata <= done_data;
                    m0_ready <= 1'b1;
                end
            end

            if (state == ST_RESP) begin
                grant <= '0;
            end

            if (do_timeout) begin
                timeout_flag <= 1'b1;
            end else if (timeout_clr) begin
                timeout_flag <= 1'b0;
            end
        end
    end

endmodule
